// File: rtl/cache_mem_arbiter.sv
// Shares one block-memory port between the I-cache and D-cache.
// One owner at a time; owner's command is registered onto mem_*, ready is routed back to the owner only.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W        = 28,
    parameter int unsigned DATA_W        = 128,
    parameter bit          DC_FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              ic_read,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_ready,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        arb_owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   rr_ptr;
    logic   grant_ic_c;
    logic   grant_dc_c;
    logic   done_c;

    // State register
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and grant selection; grants are only formed in IDLE
    always_comb begin
        state_next = state;
        grant_ic_c = 1'b0;
        grant_dc_c = 1'b0;
        case (state)
            IDLE: begin
                if (ic_read && (dc_read || dc_write)) begin
                    if (DC_FIXED_PRIO || rr_ptr) begin
                        grant_dc_c = 1'b1;
                    end else begin
                        grant_ic_c = 1'b1;
                    end
                end else if (ic_read) begin
                    grant_ic_c = 1'b1;
                end else if (dc_read || dc_write) begin
                    grant_dc_c = 1'b1;
                end
                if (grant_ic_c || grant_dc_c) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ready strobes: zero-latency pass-through of mem_ready to the owner, suppressed under reset
    always_comb begin
        done_c   = 1'b0;
        ic_ready = 1'b0;
        dc_ready = 1'b0;
        if ((state == BUSY) && mem_ready && !proc_reset) begin
            done_c = 1'b1;
        end
        ic_ready = done_c && arb_owner[0];
        dc_ready = done_c && arb_owner[1];
    end

    // Registered memory command, owner and round-robin pointer
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            arb_owner <= 2'b00;
            rr_ptr    <= 1'b0;
        end else if (grant_ic_c) begin
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= ic_addr;
            mem_wdata <= '0;
            arb_owner <= 2'b01;
        end else if (grant_dc_c) begin
            mem_read  <= !dc_write;
            mem_write <= dc_write;
            mem_addr  <= dc_addr;
            mem_wdata <= dc_wdata;
            arb_owner <= 2'b10;
        end else if (done_c) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            arb_owner <= 2'b00;
            rr_ptr    <= arb_owner[0];
        end
    end

    assign ic_rdata = mem_rdata;
    assign dc_rdata = mem_rdata;

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Two-client memory arbiter that shares the single 128-bit block memory port between the read-only instruction cache and the read/write data cache of the 5-stage RISC-V core. Each cache keeps its own unchanged memory-side handshake: level request held until ready. The arbiter grants one client at a time, registers that client's command onto the memory port, and routes `mem_ready` back to the owner only. Default arbitration is round-robin on contention; a parameter selects fixed data-cache priority.

## Interface
- `ADDR_W`, 28, block address width (word address bits [29:2]).
- `DATA_W`, 128, block data width.
- `DC_FIXED_PRIO`, 0: 0 = round-robin on contention; 1 = data cache always wins.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `proc_reset`  in  1  synchronous, active-high reset.
- `ic_read`  in  1  I-cache block read request, held until `ic_ready`.
- `ic_addr`  in  ADDR_W  I-cache block address.
- `ic_rdata`  out  DATA_W  read data to the I-cache; equals `mem_rdata`.
- `ic_ready`  out  1  I-cache transaction complete; one cycle.
- `dc_read`  in  1  D-cache block read request, held until `dc_ready`.
- `dc_write`  in  1  D-cache block write request, held until `dc_ready`.
- `dc_addr`  in  ADDR_W  D-cache block address.
- `dc_wdata`  in  DATA_W  D-cache write-back block.
- `dc_rdata`  out  DATA_W  read data to the D-cache; equals `mem_rdata`.
- `dc_ready`  out  1  D-cache transaction complete; one cycle.
- `mem_read`  out  1  registered memory read strobe.
- `mem_write`  out  1  registered memory write strobe.
- `mem_addr`  out  ADDR_W  registered memory address.
- `mem_wdata`  out  DATA_W  registered memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid while `mem_ready` is high.
- `mem_ready`  in  1  memory transaction complete.
- `arb_owner`  out  2  one-hot current owner {dc, ic}; 2'b00 when the port is free.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If exactly one client requests, grant it.
  - If both request: with `DC_FIXED_PRIO`=1 the D-cache wins; otherwise the client selected by `rr_ptr` wins (0 = I-cache, 1 = D-cache).
  - On a grant, latch the address, write data and op into the `mem_*` registers. The I-cache op is always read. For the D-cache, `dc_write` takes precedence if `dc_read` and `dc_write` are both high.
  - Set `arb_owner` and go to BUSY.
  - With no request, stay in IDLE with all strobes low.
- BUSY:
  - Hold the `mem_*` registers constant.
  - On `mem_ready`, assert the owner's ready combinationally in the same cycle. Clear `mem_read`, `mem_write` and `arb_owner`, and go to DONE.
  - On a completed grant, `rr_ptr` is set to point at the non-owner.
- DONE: one turnaround cycle. Requests are ignored while the previous owner drops its request. Go to IDLE.
- `ic_rdata` and `dc_rdata` are both wired straight to `mem_rdata`. Only the ready strobes are gated by ownership.
- `mem_ready` outside BUSY is ignored: no client ready, no state change.
- A client that drops its request while BUSY is a protocol violation. The memory transaction still runs to completion and the ready pulse is still issued; it is never aborted.
- A non-owner's request is held off, with no ready, until the next IDLE evaluation.
- Reset values: state IDLE, `rr_ptr`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `arb_owner`=2'b00.
- `ic_ready` and `dc_ready` are 0 during and after reset until the first BUSY completion.
- Reset asserted mid-transaction abandons it: outputs take their reset values on the next edge and no ready pulse is issued.

## Timing
- A request is sampled at edge t in IDLE; the `mem_*` strobes and address are visible from cycle t+1.
- `mem_ready` high in cycle k (BUSY) gives the owner's ready in cycle k, with zero added response latency.
- Sequence after completion: k+1 is DONE, k+2 is IDLE evaluation, and the next grant's strobes appear at k+3.
- Minimum arbiter overhead per transaction: 1 cycle request + 2 cycles turnaround.
- `mem_read` and `mem_write` are never high together.
- The ready strobes last exactly one cycle per grant.
- A `mem_ready` pulse lasting several cycles produces only one ready pulse, because the FSM leaves BUSY after the first cycle.

## Test plan
- Reset, then a single I-cache read:
  - Stimulus: `ic_read`=1, `ic_addr`=28'h0000010; memory returns 128'hA5A5…01 with `mem_ready` 4 cycles later.
  - Response: `mem_read`=1 with `mem_addr`=28'h0000010 one cycle after the request; `ic_ready` is one cycle with that data; `dc_ready` stays 0.
- D-cache write-back then allocate:
  - Stimulus: `dc_write`=1, `dc_addr`=28'h0000123, `dc_wdata`=128'hDEAD…BEEF; after `dc_ready`, `dc_read`=1, `dc_addr`=28'h0000456.
  - Response: `mem_write` with that data, then a 2-cycle gap, then `mem_read` at 28'h0000456; the strobes never overlap.
- Contention, round-robin (`DC_FIXED_PRIO`=0):
  - Stimulus: both clients request continuously from reset.
  - Response: grants are I, D, I, D; `arb_owner` alternates 01, 10, 01, 10.
- Contention, fixed priority (`DC_FIXED_PRIO`=1):
  - Stimulus: both clients request continuously.
  - Response: the D-cache is granted every time while requesting; the I-cache is granted only when `dc_read`/`dc_write` is low.
- Spurious and long ready:
  - Stimulus: `mem_ready`=1 in IDLE; then `mem_ready` held high for 3 cycles during a BUSY transaction.
  - Response: no ready in IDLE; exactly one ready pulse for the transaction.
- Reset mid-transaction:
  - Stimulus: `proc_reset` pulsed during BUSY of a D-cache read.
  - Response: next cycle `mem_read`=0, `arb_owner`=00, no `dc_ready`; `rr_ptr`=0, so under contention the I-cache wins first.
